// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and helpers for the saturating dot-product controller:
// FSM state encoding, symmetric range limit and clamp.
package dot_product_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int maxp(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Clamp an integer into the symmetric range [-MAXP, +MAXP].
  function automatic int clamp_sym(input int value, input int width);
    int m;
    m = maxp(width);
    if (value > m) return m;
    if (value < -m) return -m;
    return value;
  endfunction

endpackage

// File: rtl/dot_product_ctrl_sat_accum_add.sv
// Combinational WIDTH-bit saturating adder for the accumulator step;
// result is clamped to the symmetric range [-MAXP, +MAXP].
module sat_accum_add
  import dot_product_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH-1:0] acc_i,
  input  logic signed [WIDTH-1:0] product_i,
  output logic signed [WIDTH-1:0] sum_o,
  output logic                    clamp_o
);

  localparam logic signed [WIDTH-1:0] MAXP_V = WIDTH'(maxp(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] ext_sum;
  logic           ovf;

  always_comb begin
    ext_sum = {acc_i[WIDTH-1], acc_i} + {product_i[WIDTH-1], product_i};
    // Bit WIDTH is the true sign; disagreement with bit WIDTH-1 means overflow.
    ovf     = ext_sum[WIDTH] ^ ext_sum[WIDTH-1];
    sum_o   = ext_sum[WIDTH-1:0];
    clamp_o = 1'b0;
    if (ovf) begin
      sum_o   = ext_sum[WIDTH] ? -MAXP_V : MAXP_V;
      clamp_o = 1'b1;
    end else if (ext_sum[WIDTH-1:0] == MIN_V) begin
      sum_o   = -MAXP_V;
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Saturating signed dot-product controller: accepts LEN operand pairs,
// accumulates clamped products and presents the result with a sticky clamp flag.
module dot_product_ctrl
  import dot_product_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN   = 4
) (
  input  logic                    clk_80,
  input  logic                    reset_80,
  input  logic                    start_80,
  input  logic                    abort_80,
  input  logic signed [WIDTH-1:0] a_80,
  input  logic signed [WIDTH-1:0] b_80,
  input  logic                    op_valid_80,
  output logic                    op_ready_80,
  output logic signed [WIDTH-1:0] result_80,
  output logic                    result_valid_80,
  input  logic                    result_ready_80,
  output logic                    sat_flag_80,
  output logic                    busy_80
);

  localparam int                      CW     = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0]           LAST   = CW'(LEN - 1);
  localparam logic signed [WIDTH-1:0] MAXP_V = WIDTH'(maxp(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    flag_q, flag_d;

  logic signed [WIDTH-1:0]   a_fix, b_fix, prod_sat, sum_sat;
  logic signed [2*WIDTH-1:0] prod_full;
  int                        prod_int, prod_lim;
  logic                      prod_clamp, sum_clamp, xfer;

  // The most negative code is folded onto -MAXP before multiplying.
  always_comb begin
    a_fix      = (a_80 == MIN_V) ? -MAXP_V : a_80;
    b_fix      = (b_80 == MIN_V) ? -MAXP_V : b_80;
    prod_full  = a_fix * b_fix;
    prod_int   = int'(prod_full);
    prod_lim   = clamp_sym(prod_int, WIDTH);
    prod_sat   = WIDTH'(prod_lim);
    prod_clamp = (prod_lim != prod_int);
  end

  sat_accum_add #(.WIDTH(WIDTH)) u_sat_accum_add (
    .acc_i     (acc_q),
    .product_i (prod_sat),
    .sum_o     (sum_sat),
    .clamp_o   (sum_clamp)
  );

  assign op_ready_80     = (state_q == ST_RUN) && !abort_80;
  assign xfer            = op_valid_80 && op_ready_80;
  assign result_valid_80 = (state_q == ST_DONE);
  assign busy_80         = (state_q != ST_IDLE);
  assign result_80       = acc_q;
  assign sat_flag_80     = flag_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    flag_d  = flag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_80) begin
          state_d = ST_RUN;
          acc_d   = '0;
          count_d = '0;
          flag_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort_80) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          acc_d  = sum_sat;
          flag_d = flag_q | prod_clamp | sum_clamp;
          if (count_q == LAST) begin
            state_d = ST_DONE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (abort_80) begin
          state_d = ST_IDLE;
        end else if (result_ready_80) begin
          if (start_80) begin
            state_d = ST_RUN;
            acc_d   = '0;
            count_d = '0;
            flag_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_80) begin
    if (reset_80) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

endmodule

// File: doc/dot_product_ctrl.md
DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: signed operand/result width; legal range 3..8.
REQ-002 Parameter LEN, default 4: terms per dot product; legal range 2..16.
REQ-003 One clock; reset is synchronous and active-high: port clk_80 input 1 rising-edge clock; port reset_80 input 1 synchronous active-high reset.
REQ-004 start_80 input 1: begin a new dot product; sampled only in IDLE or in DONE on the result-accept cycle.
REQ-005 abort_80 input 1: discard the job in progress.
REQ-006 a_80, b_80 input WIDTH each: signed two's-complement operand pair.
REQ-007 op_valid_80 input 1 / op_ready_80 output 1: operand handshake; a pair transfers when both are high.
REQ-008 result_80 output WIDTH: saturated dot product.
REQ-009 result_valid_80 output 1 / result_ready_80 input 1: result handshake.
REQ-010 sat_flag_80 output 1: at least one clamp occurred in this job; valid with result_valid_80.
REQ-011 busy_80 output 1: high in RUN and DONE.

Function
REQ-012 Symmetric range: MAXP = 2^(WIDTH-1)-1; the legal range is [-MAXP, +MAXP]. An operand equal to -2^(WIDTH-1) is treated as -MAXP and does not set sat_flag_80.
REQ-013 Each product a*b is formed at full 2*WIDTH precision, then clamped to [-MAXP, +MAXP]. A clamp sets the job's sticky flag.
REQ-014 acc_next = clamp(acc + product), computed from the sum, carry and two's-complement overflow. Positive overflow gives +MAXP; negative overflow gives -MAXP; a non-overflow sum of -2^(WIDTH-1) gives -MAXP. An overflow clamp sets the flag.
REQ-015 Clamping is per step and not sticky on the value: later terms may move the accumulator away from a rail.
REQ-016 The FSM has states IDLE, RUN and DONE.
REQ-017 IDLE: op_ready_80=0 and result_valid_80=0. On start_80=1, the next cycle is RUN with acc=0, count=0 and the flag cleared.
REQ-018 RUN: op_ready_80=1. On each transfer, acc and count update in the same cycle. op_valid_80 gaps stall without state change.
REQ-019 RUN: on the transfer with count==LEN-1, the next cycle is DONE, with result_80 = the final acc and result_valid_80=1. Latency is 1 cycle from the last transfer to result_valid_80.
REQ-020 DONE: op_ready_80=0. result_80 and sat_flag_80 are held stable until result_ready_80=1.
REQ-021 On the accept cycle, the next state is IDLE. If start_80=1 in that same cycle, the next state is RUN instead, freshly initialised.
REQ-022 start_80 is ignored in RUN and in DONE without accept.
REQ-023 abort_80=1 in RUN or DONE: the next state is IDLE, no result is delivered, and any operand offered that cycle is not consumed (op_ready_80 forced 0). abort_80 has priority over start_80 and over completion. abort_80 in IDLE has no effect.
REQ-024 The count is log2-sized to hold LEN-1 and never wraps, because completion occurs at LEN-1.

Reset
REQ-025 reset_80=1 at a clock edge forces IDLE. It also forces acc=0, count=0, result_80=0, sat_flag_80=0, result_valid_80=0, op_ready_80=0 and busy_80=0.
REQ-026 Reset has priority over all inputs. Reset mid-RUN or mid-DONE discards the job, and the first start_80 after reset behaves normally.

Structure
REQ-027 A shared package holds the FSM state encoding (IDLE, RUN, DONE), the MAXP constant function and the clamp helper.
REQ-028 One sub-module, sat_accum_add, holds the combinational WIDTH-bit saturating adder: inputs acc and product; outputs the clamped sum and an overflow-clamp flag. The FSM, counter, multiplier and product clamp stay in dot_product_ctrl.

Verification (WIDTH=4, LEN=4)
REQ-029 Clean job: a={1,2,1,-1}, b={1,1,3,2}, no gaps -> result 4 (0100), sat_flag 0, result_valid one cycle after the 4th transfer.
REQ-030 Intermediate clamp: a={2,3,-1,1}, b={3,2,4,-5} -> the steps run 6, 7 (clamped from 12), 3, -2. Final result -2 (1110), sat_flag 1.
REQ-031 Product clamp and illegal input: a={7,-7,-7,-8}, b={7,7,7,1} -> steps 7, 0, -7, -7 (-8 is treated as -7, so the sum -14 clamps to -7). Result 1001, sat_flag 1.
REQ-032 Backpressure: insert random op_valid_80 gaps and hold result_ready_80=0 for 5 cycles -> the result matches the gap-free run and is held stable. Assert start_80 on the accept cycle -> RUN the next cycle with acc=0.
REQ-033 Abort after 2 transfers -> IDLE next cycle, no result_valid_80, the next job's result is correct.
REQ-034 reset_80 pulse after 3 transfers -> all outputs 0, IDLE. A following clean job gives result 4.
